// File: rtl/grey6_rx_monitor.sv
// grey6_rx_monitor: syncs grey_in to clk, decodes to bin, flags step/skip, lock FSM (locked) and saturating err_cnt with clr_err
module grey6_rx_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STEPS  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       grey_in,
    input  logic             clr_err,
    output logic [5:0]       bin,
    output logic             step,
    output logic             skip,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);
    typedef enum logic [1:0] {FILL, ACQ, TRACK} state_t;
    localparam logic [1:0] FILL_LAST = 2'(SYNC_STAGES);
    localparam logic [3:0] LOCK_N    = 4'(LOCK_STEPS);
    state_t                         state;
    logic [SYNC_STAGES-1:0][5:0]    sync;
    logic [5:0]                     s, p, d, bs, bp;
    logic [1:0]                     fc;
    logic [3:0]                     sc;
    logic                           is_step, is_skip;
    function automatic logic [5:0] g2b(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
    always_comb begin
        s       = sync[SYNC_STAGES-1];
        d       = s ^ p;
        bs      = g2b(s);
        bp      = g2b(p);
        is_step = (d != 6'd0) && ((d & (d - 6'd1)) == 6'd0) && (bs == bp + 6'd1);
        is_skip = (d != 6'd0) && !is_step;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            p       <= '0;
            bin     <= '0;
            step    <= 1'b0;
            skip    <= 1'b0;
            locked  <= 1'b0;
            err_cnt <= '0;
            state   <= FILL;
            fc      <= '0;
            sc      <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], grey_in};
            p    <= s;
            bin  <= bs;
            step <= (state != FILL) && is_step;
            skip <= (state != FILL) && is_skip;
            if (state == FILL) begin
                fc <= fc + 2'd1;
                if (fc == FILL_LAST) state <= ACQ;
            end else begin
                if (is_skip) begin
                    state  <= ACQ;
                    locked <= 1'b0;
                    sc     <= '0;
                end else if (is_step && state == ACQ) begin
                    if (sc + 4'd1 == LOCK_N) begin
                        state  <= TRACK;
                        locked <= 1'b1;
                        sc     <= '0;
                    end else begin
                        sc <= sc + 4'd1;
                    end
                end
                err_cnt <= clr_err ? ERR_W'(is_skip) :
                           (is_skip && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
            end
        end
    end
endmodule
